// File: rtl/miner_dispatch_if.sv
// Job/ticket bus between the UART side, the miner cores and the dispatcher.
// The master drives jobs, core tickets and ticket_ready; the slave is the dispatcher.
interface miner_dispatch_if #(
  parameter int unsigned CORE_LOG2 = 2
);
  localparam int unsigned NUM_CORES = 1 << CORE_LOG2;
  localparam int unsigned IDX_W     = (CORE_LOG2 > 0) ? CORE_LOG2 : 1;

  logic                    new_work;
  logic [31:0]             nonce_min;
  logic [31:0]             nonce_max;
  logic                    core_reset;
  logic [NUM_CORES-1:0]    core_en;
  logic [32*NUM_CORES-1:0] core_nonce_min;
  logic [32*NUM_CORES-1:0] core_nonce_max;
  logic [NUM_CORES-1:0]    core_ticket;
  logic [32*NUM_CORES-1:0] core_golden_nonce;
  logic                    ticket_valid;
  logic                    ticket_ready;
  logic [31:0]             ticket_nonce;
  logic [IDX_W-1:0]        ticket_core;
  logic                    busy;
  logic [7:0]              drop_count;

  modport master (
    output new_work, nonce_min, nonce_max, core_ticket, core_golden_nonce, ticket_ready,
    input  core_reset, core_en, core_nonce_min, core_nonce_max,
           ticket_valid, ticket_nonce, ticket_core, busy, drop_count
  );

  modport slave (
    input  new_work, nonce_min, nonce_max, core_ticket, core_golden_nonce, ticket_ready,
    output core_reset, core_en, core_nonce_min, core_nonce_max,
           ticket_valid, ticket_nonce, ticket_core, busy, drop_count
  );
endinterface

// File: rtl/miner_dispatch.sv
// Splits a job nonce range across NUM_CORES miners, starts them together and
// funnels their golden tickets through per-core pending regs into a ticket FIFO.
module miner_dispatch #(
  parameter int unsigned CORE_LOG2 = 2,
  parameter int unsigned FIFO_LOG2 = 3
) (
  input logic            hash_clk,
  input logic            reset_n,
  miner_dispatch_if.slave bus
);
  localparam int unsigned NUM_CORES = 1 << CORE_LOG2;
  localparam int unsigned IDX_W     = (CORE_LOG2 > 0) ? CORE_LOG2 : 1;
  localparam int unsigned DEPTH     = 1 << FIFO_LOG2;
  localparam int unsigned PTR_W     = (FIFO_LOG2 > 0) ? FIFO_LOG2 : 1;
  localparam int unsigned CNT_W     = FIFO_LOG2 + 1;
  localparam int unsigned LAST      = NUM_CORES - 1;

  typedef enum logic [1:0] {IDLE, SPLIT, START, RUN} state_t;

  state_t                  state;
  logic [31:0]             job_max;
  logic [32:0]             chunk;
  logic                    span_zero;
  logic [31:0]             run_min;
  logic [IDX_W-1:0]        idx;
  logic                    core_reset_q;
  logic                    busy_q;
  logic [NUM_CORES-1:0]    core_en_q;
  logic [32*NUM_CORES-1:0] core_min_q;
  logic [32*NUM_CORES-1:0] core_max_q;
  logic [32:0]             span_c;

  assign span_c = {1'b0, bus.nonce_max} - {1'b0, bus.nonce_min} + 33'd1;

  // Job FSM: one core's range is produced per SPLIT cycle via a running base.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      job_max      <= '0;
      chunk        <= '0;
      span_zero    <= 1'b0;
      run_min      <= '0;
      idx          <= '0;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      core_en_q    <= '0;
      core_min_q   <= '0;
      core_max_q   <= '0;
    end else begin
      core_reset_q <= 1'b0;
      if (bus.new_work) begin
        job_max   <= bus.nonce_max;
        span_zero <= (bus.nonce_max < bus.nonce_min);
        chunk     <= span_c >> CORE_LOG2;
        run_min   <= bus.nonce_min;
        idx       <= '0;
        busy_q    <= 1'b1;
        state     <= SPLIT;
      end else begin
        case (state)
          SPLIT: begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (IDX_W'(i) == idx) begin
                if (span_zero || (chunk == 33'd0 && i != 0)) begin
                  core_en_q[i]              <= 1'b0;
                  core_min_q[32*i +: 32]    <= '0;
                  core_max_q[32*i +: 32]    <= '0;
                end else begin
                  core_en_q[i]              <= 1'b1;
                  core_min_q[32*i +: 32]    <= run_min;
                  core_max_q[32*i +: 32]    <= (i == LAST || chunk == 33'd0) ?
                                               job_max : run_min + chunk[31:0] - 32'd1;
                end
              end
            end
            run_min <= run_min + chunk[31:0];
            if (idx == IDX_W'(LAST)) begin
              state        <= span_zero ? IDLE : START;
              busy_q       <= !span_zero;
              core_reset_q <= !span_zero;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          START: begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  logic [NUM_CORES-1:0] pend_v;
  logic [31:0]          pend_n [NUM_CORES];
  logic [IDX_W-1:0]     rr_ptr;
  logic [31:0]          fifo_nonce [DEPTH];
  logic [IDX_W-1:0]     fifo_core  [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [7:0]           drop_q;

  logic                 gnt_any, push, pop, full, accept, ticket_valid_c;
  logic [IDX_W-1:0]     gnt_idx, scan;
  logic [NUM_CORES-1:0] gnt_vec, store, drop_hit;
  logic [8:0]           drop_sum;
  logic [7:0]           drop_next;

  // Round-robin pick of the first pending core at or after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      scan = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (pend_v[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
    end
  end

  assign ticket_valid_c = (count != '0);
  assign full           = (count == CNT_W'(DEPTH));
  assign pop            = ticket_valid_c && bus.ticket_ready;
  assign push           = gnt_any && (!full || pop);
  assign accept         = (state == RUN) && !bus.new_work;

  always_comb begin
    gnt_vec  = '0;
    store    = '0;
    drop_hit = '0;
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_CORES; i++) begin
      gnt_vec[i]  = push && (gnt_idx == IDX_W'(i));
      drop_hit[i] = accept && bus.core_ticket[i] && pend_v[i] && !gnt_vec[i];
      store[i]    = accept && bus.core_ticket[i] && !drop_hit[i];
      if (drop_hit[i]) drop_sum = drop_sum + 9'd1;
    end
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Ticket control; new_work flushes everything except the drop counter.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= '0;
    end else begin
      drop_q <= drop_next;
      if (bus.new_work) begin
        pend_v <= '0;
        rr_ptr <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        pend_v <= (pend_v & ~gnt_vec) | store;
        if (push) begin
          wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
          rr_ptr <= IDX_W'((int'(gnt_idx) + 1) % NUM_CORES);
        end
        if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind valid flags.
  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (store[i]) pend_n[i] <= bus.core_golden_nonce[32*i +: 32];
    end
    if (push && !bus.new_work) begin
      fifo_nonce[wr_ptr] <= pend_n[gnt_idx];
      fifo_core[wr_ptr]  <= gnt_idx;
    end
  end

  assign bus.core_reset     = core_reset_q;
  assign bus.core_en        = core_en_q;
  assign bus.core_nonce_min = core_min_q;
  assign bus.core_nonce_max = core_max_q;
  assign bus.busy           = busy_q;
  assign bus.drop_count     = drop_q;
  assign bus.ticket_valid   = ticket_valid_c;
  assign bus.ticket_nonce   = ticket_valid_c ? fifo_nonce[rd_ptr] : 32'd0;
  assign bus.ticket_core    = ticket_valid_c ? fifo_core[rd_ptr] : '0;
endmodule
